pwm_bank: RTL and testbench



---
 rtl/pwm_bank_if.sv | 27 ++
 rtl/pwm_bank.sv | 227 ++++++++++++++++++++++
 tb/tb_pwm_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// pwm_bank_if -- Wishbone slave bus bundle for pwm_bank.
//
// Signals (directions as seen by the slave):
//   PWM_STB_I   strobe
//   PWM_WE_I    write enable
//   PWM_ADR_I   6-bit word address
//   PWM_DAT_I   32-bit write data
//   PWM_ACK_O   acknowledge, one cycle per access
//   PWM_DAT_O   32-bit read data, valid while PWM_ACK_O=1
interface pwm_bank_if;
    logic        PWM_STB_I;
    logic        PWM_WE_I;
    logic [5:0]  PWM_ADR_I;
    logic [31:0] PWM_DAT_I;
    logic        PWM_ACK_O;
    logic [31:0] PWM_DAT_O;

    modport slave (
        input  PWM_STB_I, PWM_WE_I, PWM_ADR_I, PWM_DAT_I,
        output PWM_ACK_O, PWM_DAT_O
    );

    modport master (
        output PWM_STB_I, PWM_WE_I, PWM_ADR_I, PWM_DAT_I,
        input  PWM_ACK_O, PWM_DAT_O
    );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank -- NCH-channel Wishbone PWM generator sharing one prescaled
// period counter. Each channel has its own duty and output polarity.
//
// Ports:
//   CLK_I     system clock
//   RST_N_I   asynchronous active-low reset
//   bus       Wishbone slave (pwm_bank_if.slave)
//   PWM_O     registered PWM outputs, bit n = channel n
//   PERIOD_O  one-clock pulse, registered from the period wrap
//
// Register map (word address):
//   0x00 CTRL      [0] EN, [1] LOAD (write-1 pulse, reads 0)
//   0x01 PRESCALE  [PW-1:0]
//   0x02 TOP       [CW-1:0]
//   0x03 POL       [NCH-1:0]
//   0x04 STATUS    [0] PEND, [CW+15:16] current count (read-only)
//   0x20+n DUTY[n] [CW-1:0]
//
// Build option PWM_SHADOW_EN: when defined, DUTY/TOP writes land in shadow
// registers copied to the active set on a wrap, on LOAD, or on EN 0->1.
// When undefined, DUTY/TOP writes go straight to the active registers.
module pwm_bank #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int PW  = 16
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    pwm_bank_if.slave        bus,
    output logic [NCH-1:0]   PWM_O,
    output logic             PERIOD_O
);

    localparam logic [5:0] ADR_CTRL   = 6'h00;
    localparam logic [5:0] ADR_PRE    = 6'h01;
    localparam logic [5:0] ADR_TOP    = 6'h02;
    localparam logic [5:0] ADR_POL    = 6'h03;
    localparam logic [5:0] ADR_STATUS = 6'h04;
    localparam logic [5:0] ADR_DUTY0  = 6'h20;

    // bus
    logic                    ack_q;
    logic [31:0]             dat_q, dat_d;
    logic                    wr, rd;
    logic                    wr_ctrl, wr_pre, wr_top, wr_pol;
    logic [NCH-1:0]          wr_duty;

    // configuration
    logic                    en_q, en_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [NCH-1:0]          pol_q, pol_d;
    logic [CW-1:0]           top_act_q, top_act_d;
    logic [NCH-1:0][CW-1:0]  duty_act_q, duty_act_d;

    // counters and outputs
    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    tick, wrap;
    logic [NCH-1:0]          pwm_q, pwm_d;
    logic                    period_q;

    // read-back views
    logic [CW-1:0]           top_rd;
    logic [NCH-1:0][CW-1:0]  duty_rd;
    logic                    pend_rd;

    logic                    unused_dat;
    assign unused_dat = ^bus.PWM_DAT_I;

`ifdef PWM_SHADOW_EN
    logic [CW-1:0]           top_sh_q, top_sh_d;
    logic [NCH-1:0][CW-1:0]  duty_sh_q, duty_sh_d;
    logic                    pend_q, pend_d;
    logic                    load;
`endif

    // ------------------------------------------------------------------
    // Bus decode: every access owns exactly one cycle with ACK low.
    // ------------------------------------------------------------------
    always_comb begin
        wr      = bus.PWM_STB_I & bus.PWM_WE_I & ~ack_q;
        rd      = bus.PWM_STB_I & ~bus.PWM_WE_I & ~ack_q;
        wr_ctrl = wr & (bus.PWM_ADR_I == ADR_CTRL);
        wr_pre  = wr & (bus.PWM_ADR_I == ADR_PRE);
        wr_top  = wr & (bus.PWM_ADR_I == ADR_TOP);
        wr_pol  = wr & (bus.PWM_ADR_I == ADR_POL);
        wr_duty = '0;
        for (int n = 0; n < NCH; n++)
            wr_duty[n] = wr & (bus.PWM_ADR_I == ADR_DUTY0 + 6'(n));
    end

    // ------------------------------------------------------------------
    // Prescaler and period counter.
    // ------------------------------------------------------------------
    always_comb begin
        // >= rather than == so that lowering PRESCALE below the running
        // pcnt ticks at once instead of running pcnt through its full range.
        tick = (pcnt_q >= pre_q);
        // >= against TOP also keeps cnt in range when TOP shrinks.
        wrap = en_q & tick & (cnt_q >= top_act_q);
        if (!en_q) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick)
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
            else
                cnt_d = cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers.
    // ------------------------------------------------------------------
    always_comb begin
        en_d  = wr_ctrl ? bus.PWM_DAT_I[0]      : en_q;
        pre_d = wr_pre  ? bus.PWM_DAT_I[PW-1:0] : pre_q;
        pol_d = wr_pol  ? bus.PWM_DAT_I[NCH-1:0] : pol_q;
`ifdef PWM_SHADOW_EN
        // A write coinciding with a load: the active copy takes the old
        // shadow (non-blocking read of *_sh_q) and PEND stays set.
        load      = wrap | (wr_ctrl & bus.PWM_DAT_I[1])
                         | (wr_ctrl & bus.PWM_DAT_I[0] & ~en_q);
        top_sh_d  = wr_top ? bus.PWM_DAT_I[CW-1:0] : top_sh_q;
        top_act_d = load ? top_sh_q : top_act_q;
        duty_sh_d  = duty_sh_q;
        duty_act_d = load ? duty_sh_q : duty_act_q;
        for (int n = 0; n < NCH; n++)
            if (wr_duty[n]) duty_sh_d[n] = bus.PWM_DAT_I[CW-1:0];
        if (wr_top | (|wr_duty))
            pend_d = 1'b1;
        else if (load)
            pend_d = 1'b0;
        else
            pend_d = pend_q;
        top_rd  = top_sh_q;
        duty_rd = duty_sh_q;
        pend_rd = pend_q;
`else
        top_act_d  = wr_top ? bus.PWM_DAT_I[CW-1:0] : top_act_q;
        duty_act_d = duty_act_q;
        for (int n = 0; n < NCH; n++)
            if (wr_duty[n]) duty_act_d[n] = bus.PWM_DAT_I[CW-1:0];
        top_rd  = top_act_q;
        duty_rd = duty_act_q;
        pend_rd = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Compare and polarity.
    // ------------------------------------------------------------------
    always_comb begin
        pwm_d = '0;
        for (int n = 0; n < NCH; n++)
            pwm_d[n] = (en_q & (cnt_q < duty_act_q[n])) ^ pol_q[n];
    end

    // ------------------------------------------------------------------
    // Read mux; data is only loaded in the access cycle, zero otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        dat_d = '0;
        if (rd) begin
            case (bus.PWM_ADR_I)
                ADR_CTRL:   dat_d[0]        = en_q;
                ADR_PRE:    dat_d[PW-1:0]   = pre_q;
                ADR_TOP:    dat_d[CW-1:0]   = top_rd;
                ADR_POL:    dat_d[NCH-1:0]  = pol_q;
                ADR_STATUS: begin
                    dat_d[0]       = pend_rd;
                    dat_d[CW+15:16] = cnt_q;
                end
                default: begin
                    for (int n = 0; n < NCH; n++)
                        if (bus.PWM_ADR_I == ADR_DUTY0 + 6'(n))
                            dat_d[CW-1:0] = duty_rd[n];
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            en_q       <= 1'b0;
            pre_q      <= '0;
            pol_q      <= '0;
            top_act_q  <= '1;
            duty_act_q <= '0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            period_q   <= 1'b0;
`ifdef PWM_SHADOW_EN
            top_sh_q   <= '1;
            duty_sh_q  <= '0;
            pend_q     <= 1'b0;
`endif
        end else begin
            ack_q      <= bus.PWM_STB_I & ~ack_q;
            dat_q      <= dat_d;
            en_q       <= en_d;
            pre_q      <= pre_d;
            pol_q      <= pol_d;
            top_act_q  <= top_act_d;
            duty_act_q <= duty_act_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            period_q   <= wrap;
`ifdef PWM_SHADOW_EN
            top_sh_q   <= top_sh_d;
            duty_sh_q  <= duty_sh_d;
            pend_q     <= pend_d;
`endif
        end
    end

    assign bus.PWM_ACK_O = ack_q;
    assign bus.PWM_DAT_O = dat_q;
    assign PWM_O         = pwm_q;
    assign PERIOD_O      = period_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank -- directed bench for pwm_bank (NCH=4, CW=8, PW=16).
// Shadow-load scenarios run when PWM_SHADOW_EN is defined; the direct-write
// TOP-shrink scenario runs otherwise.
module tb_pwm_bank;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int PW  = 16;

    logic           CLK_I   = 1'b0;
    logic           RST_N_I = 1'b0;
    logic [NCH-1:0] PWM_O;
    logic           PERIOD_O;

    always #5 CLK_I = ~CLK_I;

    pwm_bank_if bus();

    pwm_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
        .CLK_I    (CLK_I),
        .RST_N_I  (RST_N_I),
        .bus      (bus),
        .PWM_O    (PWM_O),
        .PERIOD_O (PERIOD_O)
    );

    int          nchk = 0;
    int          nerr = 0;
    int          hi [NCH];
    int          np;
    int          k;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wb_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b1; bus.PWM_WE_I = 1'b1;
        bus.PWM_ADR_I = a;    bus.PWM_DAT_I = d;
        @(posedge CLK_I); #1;
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b0; bus.PWM_WE_I = 1'b0;
    endtask

    task automatic wb_rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b1; bus.PWM_WE_I = 1'b0;
        bus.PWM_ADR_I = a;
        @(posedge CLK_I); #1;
        chk("rd_ack", 32'(bus.PWM_ACK_O), 32'd1);
        d = bus.PWM_DAT_O;
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b0;
    endtask

    task automatic count_win(input int n);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        np = 0;
        repeat (n) begin
            @(posedge CLK_I); #1;
            for (int c = 0; c < NCH; c++) hi[c] += int'(PWM_O[c]);
            np += int'(PERIOD_O);
        end
    endtask

    // Returns the number of clocks until the next PERIOD_O pulse.
    task automatic wait_period(input int bound, output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK_I); #1;
            cyc++;
        end while (!PERIOD_O && cyc < bound);
        if (!PERIOD_O) chk("period_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.PWM_STB_I = 1'b0; bus.PWM_WE_I = 1'b0;
        bus.PWM_ADR_I = '0;   bus.PWM_DAT_I = '0;

        // reset state
        #12;
        chk("rst_pwm",    32'(PWM_O), 32'd0);
        chk("rst_period", 32'(PERIOD_O), 32'd0);
        chk("rst_ack",    32'(bus.PWM_ACK_O), 32'd0);
        chk("rst_dat",    bus.PWM_DAT_O, 32'd0);
        @(negedge CLK_I); RST_N_I = 1'b1;
        wb_rd(6'h02, rd); chk("rst_top", rd, 32'hFF);
        wb_rd(6'h04, rd); chk("rst_status", rd, 32'd0);
        wb_rd(6'h00, rd); chk("rst_ctrl", rd, 32'd0);

        // configure: period 10 clocks, duties 3/0/12/5
        wb_wr(6'h01, 32'd0);
        wb_wr(6'h02, 32'd9);
        wb_wr(6'h20, 32'd3);
        wb_wr(6'h21, 32'd0);
        wb_wr(6'h22, 32'd12);
        wb_wr(6'h23, 32'd5);
        wb_rd(6'h22, rd); chk("duty2_rb", rd, 32'd12);
        wb_rd(6'h24, rd); chk("unmapped_duty4", rd, 32'd0);
        wb_rd(6'h10, rd); chk("unmapped_10", rd, 32'd0);
        wb_wr(6'h00, 32'd1);

        wait_period(40, k);
        count_win(20);
        chk("ch0_30pct",  32'(hi[0]), 32'd6);
        chk("ch1_0pct",   32'(hi[1]), 32'd0);
        chk("ch2_100pct", 32'(hi[2]), 32'd20);
        chk("ch3_50pct",  32'(hi[3]), 32'd10);
        chk("period_cnt", 32'(np), 32'd2);
        wait_period(40, k);
        wait_period(40, k);
        chk("period_len", 32'(k), 32'd10);
        wb_rd(6'h04, rd); chk("pend_after_en", 32'(rd[0]), 32'd0);

        // POL latency: still old on the commit edge, new one clock later
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b1; bus.PWM_WE_I = 1'b1;
        bus.PWM_ADR_I = 6'h03; bus.PWM_DAT_I = 32'h2;
        @(posedge CLK_I); #1;
        chk("pol_lat1", 32'(PWM_O[1]), 32'd0);
        @(negedge CLK_I);
        bus.PWM_STB_I = 1'b0; bus.PWM_WE_I = 1'b0;
        @(posedge CLK_I); #1;
        chk("pol_lat2", 32'(PWM_O[1]), 32'd1);
        count_win(20);
        chk("ch1_inv", 32'(hi[1]), 32'd20);
        chk("ch0_pol0", 32'(hi[0]), 32'd6);

`ifdef PWM_SHADOW_EN
        // mid-period DUTY write stays pending until the wrap
        wait_period(40, k);
        wb_wr(6'h20, 32'd7);
        wb_rd(6'h04, rd); chk("pend_set", 32'(rd[0]), 32'd1);
        repeat (4) @(posedge CLK_I);
        #1 chk("duty_hold", 32'(PWM_O[0]), 32'd0);
        wait_period(20, k);
        wb_rd(6'h04, rd); chk("pend_clr", 32'(rd[0]), 32'd0);
        count_win(10);
        chk("duty7", 32'(hi[0]), 32'd7);

        // write in the wrap cycle: old shadow loads, new one waits a period
        wait_period(20, k);
        repeat (9) @(posedge CLK_I);
        wb_wr(6'h20, 32'd2);
        wb_rd(6'h04, rd); chk("pend_wrapwr", 32'(rd[0]), 32'd1);
        count_win(10);
        chk("wrapwr_old", 32'(hi[0]), 32'd7);
        wait_period(20, k);
        count_win(10);
        chk("wrapwr_new", 32'(hi[0]), 32'd2);

        // LOAD forces the copy and self-clears
        wb_wr(6'h20, 32'd5);
        wb_rd(6'h04, rd); chk("pend_preload", 32'(rd[0]), 32'd1);
        wb_wr(6'h00, 32'd3);
        wb_rd(6'h04, rd); chk("pend_load", 32'(rd[0]), 32'd0);
        wb_rd(6'h00, rd); chk("load_selfclr", rd, 32'd1);
`else
        // direct writes: TOP 200 -> 50 while cnt=120
        wb_wr(6'h02, 32'd200);
        wb_wr(6'h23, 32'd5);
        wb_rd(6'h04, rd); chk("pend_direct", 32'(rd[0]), 32'd0);
        wb_rd(6'h02, rd); chk("top200_rb", rd, 32'd200);
        wait_period(250, k);
        repeat (119) @(posedge CLK_I);
        wb_wr(6'h02, 32'd50);
        @(posedge CLK_I); #1;
        chk("shrink_wrap", 32'(PERIOD_O), 32'd1);
        wait_period(100, k);
        chk("period51", 32'(k), 32'd51);
`endif

        // disable: counters held, output = POL, no period pulses
        wb_wr(6'h00, 32'd0);
        repeat (2) @(posedge CLK_I);
        #1 chk("dis_pwm", 32'(PWM_O), 32'h2);
        wb_rd(6'h04, rd); chk("dis_status", rd, 32'd0);
        count_win(20);
        chk("dis_period", 32'(np), 32'd0);
        chk("dis_ch1", 32'(hi[1]), 32'd20);

        // asynchronous reset mid-period
        wb_wr(6'h00, 32'd1);
        repeat (7) @(posedge CLK_I);
        @(negedge CLK_I); #2;
        RST_N_I = 1'b0;
        #1;
        chk("arst_pwm",    32'(PWM_O), 32'd0);
        chk("arst_period", 32'(PERIOD_O), 32'd0);
        chk("arst_ack",    32'(bus.PWM_ACK_O), 32'd0);
        @(negedge CLK_I); RST_N_I = 1'b1;
        wb_rd(6'h02, rd); chk("arst_top", rd, 32'hFF);
        wb_rd(6'h04, rd); chk("arst_status", rd, 32'd0);
        wb_rd(6'h03, rd); chk("arst_pol", rd, 32'd0);
        wb_rd(6'h20, rd); chk("arst_duty0", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
